// File: rtl/nlp_pkg.sv
// Shared constants and state/enum types for the NLP sub-multiple pitch search.
package nlp_pkg;
   localparam logic [31:0] FFT_BY_SR     = 32'h0000_51EB;
   localparam logic [31:0] SR_BY_FFT     = 32'h0003_2000;
   localparam logic [31:0] POINT_EIGHT   = 32'h0000_CCCC;
   localparam logic [31:0] ONE_POINT_TWO = 32'h0001_3333;
   localparam logic [31:0] THR_NEAR_DEF  = 32'h0000_2666;
   localparam logic [31:0] THR_FAR_DEF   = 32'h0000_4CCC;

   typedef enum logic [3:0] {
      S_IDLE, S_INIT, S_DIV_GO, S_DIV_WAIT, S_CHECK, S_BOUNDS, S_THRESH,
      S_SCAN, S_DRAIN, S_NEIGH, S_UPDATE, S_FINAL, S_DONE
   } state_e;

   typedef enum logic [1:0] {RD_SCAN, RD_NLO, RD_NHI} rd_kind_e;
endpackage

// File: rtl/bin_divider.sv
// Restoring unsigned divider: one quotient bit per cycle, done BIN_W+1 cycles after start.
module bin_divider #(
   parameter int BIN_W = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [BIN_W-1:0] dividend,
   input  logic [BIN_W-1:0] divisor,
   output logic [BIN_W-1:0] quotient,
   output logic             done
);
   localparam int CW = $clog2(BIN_W + 1);

   logic [BIN_W-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic [BIN_W:0]   trial;

   always_comb begin
      rem_d  = rem_q;
      quo_d  = quo_q;
      dvs_d  = dvs_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      trial  = {rem_q, quo_q[BIN_W-1]};
      if (start) begin
         rem_d  = '0;
         quo_d  = dividend;
         dvs_d  = divisor;
         cnt_d  = CW'(BIN_W);
         busy_d = 1'b1;
      end else if (busy_q) begin
         if (cnt_q == '0) begin
            busy_d = 1'b0;
         end else begin
            if (trial >= {1'b0, dvs_q}) begin
               rem_d = BIN_W'(trial - {1'b0, dvs_q});
               quo_d = {quo_q[BIN_W-2:0], 1'b1};
            end else begin
               rem_d = trial[BIN_W-1:0];
               quo_d = {quo_q[BIN_W-2:0], 1'b0};
            end
            cnt_d = cnt_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rem_q  <= '0;
         quo_q  <= '0;
         dvs_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         rem_q  <= rem_d;
         quo_q  <= quo_d;
         dvs_q  <= dvs_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
      end
   end

   assign quotient = quo_q;
   assign done     = busy_q && (cnt_q == '0);
endmodule

// File: rtl/nlp_submultiple_search.sv
// Walks gmax_bin/mult sub-multiples and adopts any qualifying local Fw peak as the pitch bin.
// state    | meaning
// IDLE     | wait for start, sample inputs
// INIT     | mult=2, cmax=gmax_bin, prev_bin from prev_f0
// DIV_GO   | launch b = gmax_bin/mult
// DIV_WAIT | wait for divider, latch b
// CHECK    | stop test; bmin = 0.8*b
// BOUNDS   | bmax = 1.2*b, clamped
// THRESH   | pick near/far threshold, start scan
// SCAN     | issue bmin..bmax
// DRAIN    | collect last RD_LAT returns
// NEIGH    | read lmax_bin-1 / +1
// UPDATE   | adopt lmax_bin if strict local peak, mult++
// FINAL    | publish best_bin/best_f0/refined
// DONE     | done pulse
module nlp_submultiple_search
   import nlp_pkg::*;
#(
   parameter int          FW_W     = 80,
   parameter int          BIN_W    = 10,
   parameter int          NBINS    = 512,
   parameter int          MIN_BIN  = 16,
   parameter int          MAX_MULT = 16,
   parameter int          RD_LAT   = 2,
   parameter logic [31:0] THR_NEAR = THR_NEAR_DEF,
   parameter logic [31:0] THR_FAR  = THR_FAR_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [FW_W-1:0]  gmax,
   input  logic [BIN_W-1:0] gmax_bin,
   input  logic [31:0]      prev_f0,
   output logic [BIN_W-1:0] fw_addr,
   output logic             fw_rd,
   input  logic [FW_W-1:0]  fw_data,
   output logic             busy,
   output logic             done,
   output logic [BIN_W-1:0] best_bin,
   output logic [31:0]      best_f0,
   output logic             refined
);
   localparam int MULT_W = $clog2(MAX_MULT + 2);
   localparam int CNT_W  = $clog2(RD_LAT + 2);

   state_e           state_q, state_d;
   logic [FW_W-1:0]  gmax_q, gmax_d, thresh_q, thresh_d, lmax_q, lmax_d, nlo_q, nlo_d, nhi_q, nhi_d;
   logic [BIN_W-1:0] gmax_bin_q, gmax_bin_d, cmax_bin_q, cmax_bin_d, b_q, b_d;
   logic [BIN_W-1:0] bmin_q, bmin_d, bmax_q, bmax_d, lmax_bin_q, lmax_bin_d;
   logic [BIN_W-1:0] fw_addr_q, fw_addr_d, best_bin_q, best_bin_d;
   logic [31:0]      prev_f0_q, prev_f0_d, prev_bin_q, prev_bin_d, best_f0_q, best_f0_d;
   logic [MULT_W-1:0] mult_q, mult_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             fw_rd_q, fw_rd_d, busy_q, busy_d, done_q, done_d, refined_q, refined_d;
   rd_kind_e         fw_kind_q, fw_kind_d;
   logic             tag_vld_q [RD_LAT], tag_vld_d [RD_LAT];
   rd_kind_e         tag_kind_q [RD_LAT], tag_kind_d [RD_LAT];
   logic [BIN_W-1:0] tag_bin_q [RD_LAT], tag_bin_d [RD_LAT];

   logic             div_start, div_done;
   logic [BIN_W-1:0] div_quo;
   logic [31:0]      mul_a, mul_b, thr_sel;
   logic [63:0]      mul_p;
   logic [BIN_W:0]   mul_sh;
   logic [FW_W+31:0] thr_p;

   bin_divider #(.BIN_W(BIN_W)) u_div (
      .clk(clk), .rst(rst), .start(div_start), .dividend(gmax_bin_q),
      .divisor(BIN_W'(mult_q)), .quotient(div_quo), .done(div_done)
   );

   // One Q16 multiplier shared by the prev_bin, window-bound and best_f0 calculations.
   always_comb begin
      mul_a = '0;
      mul_b = '0;
      case (state_q)
         S_INIT:   begin mul_a = prev_f0_q;       mul_b = FFT_BY_SR;     end
         S_CHECK:  begin mul_a = 32'(b_q);        mul_b = POINT_EIGHT;   end
         S_BOUNDS: begin mul_a = 32'(b_q);        mul_b = ONE_POINT_TWO; end
         S_FINAL:  begin mul_a = 32'(cmax_bin_q); mul_b = SR_BY_FFT;     end
         default:  ;
      endcase
   end
   assign mul_p   = 64'(mul_a) * 64'(mul_b);
   assign mul_sh  = mul_p[16 +: BIN_W+1];
   assign thr_sel = (prev_bin_q > 32'(bmin_q) && prev_bin_q < 32'(bmax_q)) ? THR_NEAR : THR_FAR;
   assign thr_p   = (FW_W+32)'(gmax_q) * (FW_W+32)'(thr_sel);

   always_comb begin
      state_d = state_q;   gmax_d = gmax_q;         gmax_bin_d = gmax_bin_q;   prev_f0_d = prev_f0_q;
      prev_bin_d = prev_bin_q; cmax_bin_d = cmax_bin_q; b_d = b_q;           mult_d = mult_q;
      bmin_d = bmin_q;     bmax_d = bmax_q;         thresh_d = thresh_q;       lmax_d = lmax_q;
      lmax_bin_d = lmax_bin_q; nlo_d = nlo_q;       nhi_d = nhi_q;             cnt_d = cnt_q;
      fw_addr_d = fw_addr_q; fw_rd_d = fw_rd_q;     fw_kind_d = fw_kind_q;     busy_d = busy_q;
      done_d = 1'b0;       best_bin_d = best_bin_q; best_f0_d = best_f0_q;     refined_d = refined_q;
      div_start = 1'b0;
      tag_vld_d  = tag_vld_q;
      tag_kind_d = tag_kind_q;
      tag_bin_d  = tag_bin_q;

      tag_vld_d[0]  = fw_rd_q;
      tag_kind_d[0] = fw_kind_q;
      tag_bin_d[0]  = fw_addr_q;
      for (int i = 1; i < RD_LAT; i++) begin
         tag_vld_d[i]  = tag_vld_q[i-1];
         tag_kind_d[i] = tag_kind_q[i-1];
         tag_bin_d[i]  = tag_bin_q[i-1];
      end
      if (tag_vld_q[RD_LAT-1]) begin
         case (tag_kind_q[RD_LAT-1])
            RD_SCAN: if (fw_data > lmax_q) begin
               lmax_d     = fw_data;
               lmax_bin_d = tag_bin_q[RD_LAT-1];
            end
            RD_NLO:  nlo_d = fw_data;
            default: nhi_d = fw_data;
         endcase
      end

      case (state_q)
         S_IDLE: if (start) begin
            gmax_d = gmax; gmax_bin_d = gmax_bin; prev_f0_d = prev_f0;
            busy_d = 1'b1; state_d = S_INIT;
         end
         S_INIT: begin
            prev_bin_d = mul_p[63:32];
            mult_d     = MULT_W'(2);
            cmax_bin_d = gmax_bin_q;
            state_d    = S_DIV_GO;
         end
         S_DIV_GO: begin div_start = 1'b1; state_d = S_DIV_WAIT; end
         S_DIV_WAIT: if (div_done) begin b_d = div_quo; state_d = S_CHECK; end
         S_CHECK: begin
            bmin_d  = (mul_sh < (BIN_W+1)'(MIN_BIN)) ? BIN_W'(MIN_BIN) : mul_sh[BIN_W-1:0];
            state_d = (b_q < BIN_W'(MIN_BIN) || mult_q > MULT_W'(MAX_MULT)) ? S_FINAL : S_BOUNDS;
         end
         S_BOUNDS: begin
            bmax_d  = (mul_sh > (BIN_W+1)'(NBINS-2)) ? BIN_W'(NBINS-2) : mul_sh[BIN_W-1:0];
            state_d = S_THRESH;
         end
         S_THRESH: begin
            thresh_d   = FW_W'(thr_p >> 16);
            lmax_d     = '0;
            lmax_bin_d = bmin_q;
            fw_addr_d  = bmin_q;
            fw_rd_d    = 1'b1;
            fw_kind_d  = RD_SCAN;
            state_d    = S_SCAN;
         end
         S_SCAN: if (fw_addr_q == bmax_q) begin
            fw_rd_d = 1'b0;
            cnt_d   = CNT_W'(RD_LAT-1);
            state_d = S_DRAIN;
         end else begin
            fw_addr_d = fw_addr_q + 1'b1;
         end
         // lmax_d already folds in the final scan return arriving this cycle.
         S_DRAIN: if (cnt_q == '0) begin
            if (lmax_d > thresh_q) begin
               fw_addr_d = lmax_bin_d - 1'b1;
               fw_rd_d   = 1'b1;
               fw_kind_d = RD_NLO;
               cnt_d     = '0;
               state_d   = S_NEIGH;
            end else begin
               state_d = S_UPDATE;
            end
         end else begin
            cnt_d = cnt_q - 1'b1;
         end
         S_NEIGH: begin
            if (cnt_q == '0) begin
               fw_addr_d = lmax_bin_q + 1'b1;
               fw_kind_d = RD_NHI;
            end else begin
               fw_rd_d = 1'b0;
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(RD_LAT+1)) state_d = S_UPDATE;
         end
         S_UPDATE: begin
            if (lmax_q > thresh_q && lmax_q > nlo_q && lmax_q > nhi_q) cmax_bin_d = lmax_bin_q;
            mult_d  = mult_q + 1'b1;
            state_d = S_DIV_GO;
         end
         S_FINAL: begin
            best_bin_d = cmax_bin_q;
            best_f0_d  = mul_p[31:0];
            refined_d  = (cmax_bin_q != gmax_bin_q);
            done_d     = 1'b1;
            busy_d     = 1'b0;
            state_d    = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;  gmax_q <= '0;     gmax_bin_q <= '0; prev_f0_q <= '0;
         prev_bin_q <= '0;   cmax_bin_q <= '0; b_q <= '0;        mult_q <= '0;
         bmin_q <= '0;       bmax_q <= '0;     thresh_q <= '0;   lmax_q <= '0;
         lmax_bin_q <= '0;   nlo_q <= '0;      nhi_q <= '0;      cnt_q <= '0;
         fw_addr_q <= '0;    fw_rd_q <= 1'b0;  fw_kind_q <= RD_SCAN; busy_q <= 1'b0;
         done_q <= 1'b0;     best_bin_q <= '0; best_f0_q <= '0;  refined_q <= 1'b0;
         for (int i = 0; i < RD_LAT; i++) begin
            tag_vld_q[i]  <= 1'b0;
            tag_kind_q[i] <= RD_SCAN;
            tag_bin_q[i]  <= '0;
         end
      end else begin
         state_q <= state_d;       gmax_q <= gmax_d;         gmax_bin_q <= gmax_bin_d; prev_f0_q <= prev_f0_d;
         prev_bin_q <= prev_bin_d; cmax_bin_q <= cmax_bin_d; b_q <= b_d;               mult_q <= mult_d;
         bmin_q <= bmin_d;         bmax_q <= bmax_d;         thresh_q <= thresh_d;     lmax_q <= lmax_d;
         lmax_bin_q <= lmax_bin_d; nlo_q <= nlo_d;           nhi_q <= nhi_d;           cnt_q <= cnt_d;
         fw_addr_q <= fw_addr_d;   fw_rd_q <= fw_rd_d;       fw_kind_q <= fw_kind_d;   busy_q <= busy_d;
         done_q <= done_d;         best_bin_q <= best_bin_d; best_f0_q <= best_f0_d;   refined_q <= refined_d;
         tag_vld_q  <= tag_vld_d;
         tag_kind_q <= tag_kind_d;
         tag_bin_q  <= tag_bin_d;
      end
   end

   assign fw_addr  = fw_addr_q;
   assign fw_rd    = fw_rd_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign best_bin = best_bin_q;
   assign best_f0  = best_f0_q;
   assign refined  = refined_q;
endmodule
